mux_nch_rr: RTL and testbench

MUX_NCH_RR -- requirements
Module: mux_nch_rr

---
 rtl/mux_pkg.sv | 10 +
 rtl/rr_pick.sv | 38 +++
 rtl/mux_nch_rr.sv | 114 +++++++++++
 tb/tb_mux_nch_rr.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the N-channel multiplexer: mode encodings and default sizing.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

endpackage : mux_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after base, wrapping.
module rr_pick #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req_i,
  input  logic [$clog2(NCH)-1:0] base_i,
  output logic                   found_o,
  output logic [$clog2(NCH)-1:0] idx_o
);

  localparam int SELW = $clog2(NCH);

  // Rotate so that bit 0 of rot is the request at base; NCH is a power of two,
  // so the SELW-bit add wraps exactly modulo NCH.
  logic [NCH-1:0] rot;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
    logic [SELW-1:0] src;
    assign src     = base_i + SELW'(gi);
    assign rot[gi] = req_i[src];
  end

  logic [SELW-1:0] off;

  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        off     = SELW'(k);
      end
    end
  end

  assign idx_o = base_i + off;

endmodule : rr_pick

// File: rtl/mux_nch_rr.sv
// N-channel to one multiplexer with fixed or round-robin selection and a
// single registered output stage that supports full throughput.
module mux_nch_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = DEF_NCH,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          xfer_cnt
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0] ch_word [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign ch_word[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  logic            rr_found;
  logic [SELW-1:0] rr_idx;

  rr_pick #(
    .NCH(NCH)
  ) u_pick (
    .req_i  (in_valid),
    .base_i (ptr_q),
    .found_o(rr_found),
    .idx_o  (rr_idx)
  );

  logic            accept;
  logic            grant_vld;
  logic [SELW-1:0] grant;
  logic            xfer;

  assign accept = !valid_q || out_ready;

  always_comb begin
    grant     = sel;
    grant_vld = in_valid[sel];
    if (mode == MODE_RR) begin
      grant     = rr_idx;
      grant_vld = rr_found;
    end
  end

  // rst_n gates the handshake so nothing is offered upstream while in reset.
  assign xfer = grant_vld && accept && rst_n;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      data_d  = ch_word[grant];
      ch_d    = grant;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 16'd1;
      if (mode == MODE_RR) begin
        ptr_d = grant + SELW'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
  assign xfer_cnt  = cnt_q;

endmodule : mux_nch_rr

// File: tb/tb_mux_nch_rr.sv
// Directed bench for mux_nch_rr: vector table for arbitration and backpressure,
// hand-written sequences for async reset and counter wrap.
module tb_mux_nch_rr;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  mux_nch_rr #(
    .WIDTH(WIDTH),
    .NCH  (NCH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        md;
    logic [1:0]  sl;
    logic [3:0]  iv;
    logic [31:0] dat;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic [7:0]  e_data;
    logic [1:0]  e_ch;
    logic        e_ov;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] DA = 32'hA3A2A1A0;

  initial begin
    // md sl iv dat ordy | e_rdy e_data e_ch e_ov e_cnt
    vecs[0]  = '{1'b0, 2'd2, 4'b1111, DA, 1'b1, 4'b0100, 8'hA2, 2'd2, 1'b1, 16'd1};
    vecs[1]  = '{1'b0, 2'd2, 4'b1111, DA, 1'b1, 4'b0100, 8'hA2, 2'd2, 1'b1, 16'd2};
    vecs[2]  = '{1'b0, 2'd2, 4'b1111, DA, 1'b1, 4'b0100, 8'hA2, 2'd2, 1'b1, 16'd3};
    vecs[3]  = '{1'b1, 2'd2, 4'b1111, DA, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1, 16'd4};
    vecs[4]  = '{1'b1, 2'd2, 4'b1111, DA, 1'b1, 4'b0010, 8'hA1, 2'd1, 1'b1, 16'd5};
    vecs[5]  = '{1'b1, 2'd2, 4'b1111, DA, 1'b1, 4'b0100, 8'hA2, 2'd2, 1'b1, 16'd6};
    vecs[6]  = '{1'b1, 2'd2, 4'b1111, DA, 1'b1, 4'b1000, 8'hA3, 2'd3, 1'b1, 16'd7};
    vecs[7]  = '{1'b1, 2'd2, 4'b1111, DA, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1, 16'd8};
    vecs[8]  = '{1'b1, 2'd0, 4'b1001, DA, 1'b1, 4'b1000, 8'hA3, 2'd3, 1'b1, 16'd9};
    vecs[9]  = '{1'b1, 2'd0, 4'b1001, DA, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1, 16'd10};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, DA, 1'b0, 4'b0000, 8'hA0, 2'd0, 1'b1, 16'd10};
    vecs[11] = '{1'b1, 2'd0, 4'b1111, DA, 1'b0, 4'b0000, 8'hA0, 2'd0, 1'b1, 16'd10};
    vecs[12] = '{1'b1, 2'd0, 4'b1111, DA, 1'b0, 4'b0000, 8'hA0, 2'd0, 1'b1, 16'd10};
    vecs[13] = '{1'b1, 2'd0, 4'b1111, DA, 1'b1, 4'b0010, 8'hA1, 2'd1, 1'b1, 16'd11};
    vecs[14] = '{1'b1, 2'd0, 4'b0000, DA, 1'b1, 4'b0000, 8'hA1, 2'd1, 1'b0, 16'd11};
    vecs[15] = '{1'b1, 2'd0, 4'b0000, DA, 1'b0, 4'b0000, 8'hA1, 2'd1, 1'b0, 16'd11};
    vecs[16] = '{1'b0, 2'd1, 4'b1101, DA, 1'b1, 4'b0000, 8'hA1, 2'd1, 1'b0, 16'd11};
    vecs[17] = '{1'b0, 2'd3, 4'b1101, DA, 1'b0, 4'b1000, 8'hA3, 2'd3, 1'b1, 16'd12};
    vecs[18] = '{1'b1, 2'd0, 4'b1111, DA, 1'b0, 4'b0000, 8'hA3, 2'd3, 1'b1, 16'd12};
    vecs[19] = '{1'b1, 2'd0, 4'b1111, DA, 1'b1, 4'b0100, 8'hA2, 2'd2, 1'b1, 16'd13};
    vecs[20] = '{1'b1, 2'd0, 4'b0110, 32'h44332211, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1, 16'd14};

    rst_n     = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = DA;
    in_valid  = 4'b0000;
    out_ready = 1'b0;

    // Asynchronous reset from idle, checked between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_ch",    32'(out_ch),    32'd0);
    check("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
    in_valid = 4'b1111;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    in_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      mode      = vecs[i].md;
      sel       = vecs[i].sl;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].dat;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_data));
      check($sformatf("v%0d_out_ch", i),    32'(out_ch),    32'(vecs[i].e_ch));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_xfer_cnt", i),  32'(xfer_cnt),  32'(vecs[i].e_cnt));
      $display("vec %0d: mode=%0d in_valid=%b in_ready=%b out_ch=%0d out_data=%h out_valid=%0d cnt=%0d",
               i, mode, in_valid, in_ready, out_ch, out_data, out_valid, xfer_cnt);
    end

    // Reset while a word is held: everything clears without a clock edge.
    @(negedge clk);
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = DA;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    check("midrst_out_ch",    32'(out_ch),    32'd0);
    check("midrst_xfer_cnt",  32'(xfer_cnt),  32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    $display("mid-op reset: out_valid=%0d out_data=%h cnt=%0d", out_valid, out_data, xfer_cnt);

    // First edge after release transfers, and the pointer restarts at channel 0.
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post_rst_out_ch",    32'(out_ch),    32'd0);
    check("post_rst_out_data",  32'(out_data),  32'hA0);
    check("post_rst_out_valid", 32'(out_valid), 32'd1);
    check("post_rst_xfer_cnt",  32'(xfer_cnt),  32'd1);
    $display("post-reset xfer: out_ch=%0d out_data=%h cnt=%0d", out_ch, out_data, xfer_cnt);

    // Stream round-robin until the counter sits at its maximum, then wrap.
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    check("pre_wrap_cnt", 32'(xfer_cnt), 32'h0000FFFF);
    check("pre_wrap_ch",  32'(out_ch),   32'd2);
    $display("pre-wrap: cnt=%h out_ch=%0d", xfer_cnt, out_ch);
    @(posedge clk);
    #1;
    check("wrap_cnt",       32'(xfer_cnt),  32'd0);
    check("wrap_ch",        32'(out_ch),    32'd3);
    check("wrap_out_valid", 32'(out_valid), 32'd1);
    check("wrap_out_data",  32'(out_data),  32'hA3);
    $display("wrap: cnt=%h out_ch=%0d out_data=%h", xfer_cnt, out_ch, out_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_nch_rr
